// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: decodes the opcode into per-state datapath
// strobes and mux selects, and counts retired instructions.
module multi_cycle_control_unit #(
  parameter int INSTRUCTION_LEN = 16,
  parameter int COUNT_LEN       = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [INSTRUCTION_LEN-1:0] instr_i,
  input  logic                       zero_i,
  input  logic                       mem_ready_i,
  output logic                       pc_write_o,
  output logic                       ir_write_o,
  output logic                       mem_read_o,
  output logic                       mem_write_o,
  output logic                       reg_write_o,
  output logic                       iord_o,
  output logic                       mem_to_reg_o,
  output logic                       reg_dst_o,
  output logic                       alu_src_a_o,
  output logic [1:0]                 alu_src_b_o,
  output logic [2:0]                 alu_op_o,
  output logic [1:0]                 pc_src_o,
  output logic [3:0]                 state_o,
  output logic                       halted_o,
  output logic                       illegal_op_o,
  output logic [COUNT_LEN-1:0]       retired_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [3:0] OP_ADDI = 4'h4, OP_LW = 4'h5, OP_SW = 4'h6,
                         OP_BEQ  = 4'h7, OP_JMP = 4'h8, OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001;

  state_e               state_q, state_d;
  logic [COUNT_LEN-1:0] retired_q, retired_d;
  logic [3:0]           opcode;
  logic                 retire;

  assign opcode = instr_i[INSTRUCTION_LEN-1 -: 4];

  // Operand fields belong to the datapath; only the opcode steers control.
  logic unused_instr;
  assign unused_instr = ^instr_i[INSTRUCTION_LEN-5:0];

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    iord_o       = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALU_ADD;
    pc_src_o     = 2'b00;
    halted_o     = 1'b0;
    illegal_op_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b10;
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3: state_d = S_EXEC_R;
          OP_ADDI:                state_d = S_EXEC_I;
          OP_LW, OP_SW:           state_d = S_MEM_ADDR;
          OP_BEQ:                 state_d = S_BRANCH;
          OP_JMP:                 state_d = S_JUMP;
          OP_HALT:                state_d = S_HALT;
          default: begin
            state_d      = S_FETCH;
            illegal_op_o = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = {1'b0, opcode[1:0]};
        state_d     = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = S_WB_R;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode == OP_LW) ? S_MEM_RD :
                      (opcode == OP_SW) ? S_MEM_WR : S_FETCH;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (opcode == OP_ADDI);
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        reg_dst_o    = 1'b1;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = 2'b01;
        pc_write_o  = zero_i;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  halted_o = 1'b1;
      default: state_d  = S_FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + COUNT_LEN'(1) : retired_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameter INSTRUCTION_LEN, default 16, width of the instruction word; opcode SHALL be instr[INSTRUCTION_LEN-1 -: 4].
REQ-002 Parameter COUNT_LEN, default 16, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr  input  INSTRUCTION_LEN  instruction register contents, stable from DECODE onward.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write  output  1 each  datapath strobes.
REQ-009 iord, mem_to_reg, reg_dst, alu_src_a  output  1 each  mux selects; 0=PC/ALUOut/rd/PC, 1=ALUOut/MDR/rt/regA.
REQ-010 alu_src_b  output  2  00=regB, 01=constant 1, 10=sign-extended imm, 11 unused.
REQ-011 alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR.
REQ-012 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-013 state  output  4  current state encoding; halted  output  1; illegal_op  output  1 (one-cycle pulse); retired  output  COUNT_LEN.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 JMP, F HALT; 9-E illegal.
REQ-015 States and encodings SHALL be: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_MEM 8, BRANCH 9, JUMP 10, HALT 11.
REQ-016 Outputs not listed for a state SHALL be 0; outputs are decoded from state, gated only by mem_ready and zero as stated.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD; ir_write=pc_write=mem_ready, pc_src=00; to DECODE when mem_ready=1, else hold.
REQ-018 DECODE: alu_src_a=0, alu_src_b=10, alu_op=ADD; next: opcodes 0-3 EXEC_R, 4 EXEC_I, 5/6 MEM_ADDR, 7 BRANCH, 8 JUMP, F HALT, illegal FETCH with illegal_op=1 this cycle.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op={1'b0,opcode[1:0]}; to WB_R.
REQ-020 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD; to WB_R.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; to MEM_RD if LW, MEM_WR if SW.
REQ-022 MEM_RD: mem_read=1, iord=1; hold until mem_ready=1, then WB_MEM.
REQ-023 MEM_WR: mem_write=1, iord=1; hold until mem_ready=1, then FETCH.
REQ-024 WB_R: reg_write=1, mem_to_reg=0, reg_dst=1 for ADDI else 0; to FETCH.
REQ-025 WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=1; to FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=zero; to FETCH.
REQ-027 JUMP: pc_write=1, pc_src=10; to FETCH.
REQ-028 HALT: halted=1, all strobes 0; remains until reset.
REQ-029 Latency with mem_ready held 1: R/ADDI 4 cycles, LW 5, SW 4, BEQ/JMP 3.
REQ-030 retired SHALL increment by 1 on every transition into FETCH from WB_R, WB_MEM, MEM_WR, BRANCH or JUMP; illegal opcodes and HALT SHALL NOT count; wraps modulo 2^COUNT_LEN.

Reset
REQ-031 reset=1 at a rising edge SHALL force state=FETCH, retired=0, halted=0, illegal_op=0, in any state including mid memory wait or HALT.
REQ-032 The pending access SHALL be abandoned on reset; no strobe other than FETCH's mem_read may be asserted in the following cycle.

Verification
REQ-033 Reset, instr=0x0123 (ADD), mem_ready=1 -> states 0,1,2,7,0; reg_write=1 only in WB_R with reg_dst=0; retired=1.
REQ-034 instr=0x5xxx (LW), mem_ready low 3 cycles in MEM_RD -> state held 5 for 3 cycles, mem_read=iord=1 throughout, then WB_MEM with mem_to_reg=1.
REQ-035 instr=0x7xxx (BEQ) with zero=1, then zero=0 -> pc_write=1 with pc_src=01 first, pc_write=0 second; retired advances by 2.
REQ-036 instr=0xAxxx -> illegal_op pulses once in DECODE, returns to FETCH, retired unchanged.
REQ-037 instr=0xFxxx -> state 11, halted=1 held 20 cycles; reset asserted -> state 0, halted=0, retired=0.
REQ-038 Reset asserted during MEM_WR wait -> next cycle state=0, mem_write=0.
